// File: rtl/dm_pkg.sv
// Shared types and helpers for the byte-write-enable data memory.
package dm_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Widest data word the merge helper handles; callers size-cast in and out.
  localparam int unsigned MAX_DATA_W = 1024;
  localparam int unsigned MAX_BYTES  = MAX_DATA_W / 8;

  function automatic int unsigned bytes_of(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic logic [MAX_DATA_W-1:0] strb_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] wdata,
    input logic [MAX_BYTES-1:0]  wstrb
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_word;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dm_bwe_mem_if.sv
// Request/response bus between the MEM stage and the data memory.
interface dm_bwe_mem_if
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic                          req_valid;
  logic                          req_ready;
  logic                          req_write;
  logic [ADDR_W-1:0]             req_addr;
  logic [DATA_W-1:0]             req_wdata;
  logic [bytes_of(DATA_W)-1:0]   req_wstrb;
  logic                          rsp_valid;
  logic [DATA_W-1:0]             rsp_rdata;
  logic                          rsp_err;
  logic                          init_busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );
endinterface

// File: rtl/dm_rd_pipe.sv
// Read-response delay line; the last stage holds its contents between responses.
module dm_rd_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_err,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic              out_err,
  output logic [DATA_W-1:0] out_data
);

  logic [RD_LAT-1:0] v;
  logic [RD_LAT-1:0] e;
  logic [DATA_W-1:0] d [RD_LAT];

  // Payload only advances with its valid bit, so idle cycles keep the last response.
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      e <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) d[i] <= '0;
    end else begin
      v[0] <= in_valid;
      if (in_valid) begin
        e[0] <= in_err;
        d[0] <= in_data;
      end
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) begin
          e[i] <= e[i-1];
          d[i] <= d[i-1];
        end
      end
    end
  end

  assign out_valid = v[RD_LAT-1];
  assign out_err   = e[RD_LAT-1];
  assign out_data  = d[RD_LAT-1];

endmodule

// File: rtl/dm_bwe_mem.sv
// Single-port data memory with byte strobes, valid/ready requests,
// configurable read latency and a post-reset one-word-per-cycle clear sweep.
module dm_bwe_mem
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned DEPTH        = 65536,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned CLEAR_ON_RST = 1
) (
  input  logic         clk,
  input  logic         rst,
  dm_bwe_mem_if.slave  bus
);

  localparam int unsigned     BYTES   = bytes_of(DATA_W);
  localparam int unsigned     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_W  = (ADDR_W+1)'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W:0]   clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  clr_idx;
  logic [DATA_W-1:0] cur_word;
  logic [DATA_W-1:0] merged;
  logic              rd_fire;
  logic              rd_err;
  logic [DATA_W-1:0] rd_data;
  logic              pipe_valid;
  logic              pipe_err;
  logic [DATA_W-1:0] pipe_data;

  assign bus.req_ready = !rst && (state == RUN);
  assign bus.init_busy = rst ? (CLEAR_ON_RST != 0) : (state == INIT);
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    in_range = ({1'b0, bus.req_addr} < DEPTH_W);
    idx      = bus.req_addr[IDX_W-1:0];
    clr_idx  = clr_cnt[IDX_W-1:0];
    cur_word = mem[idx];
    merged   = DATA_W'(strb_merge(MAX_DATA_W'(cur_word),
                                  MAX_DATA_W'(bus.req_wdata),
                                  MAX_BYTES'(bus.req_wstrb)));
    rd_fire  = accept && !bus.req_write;
    rd_err   = !in_range;
    rd_data  = in_range ? cur_word : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= (CLEAR_ON_RST != 0) ? INIT : RUN;
      clr_cnt <= '0;
    end else if (state == INIT) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == LAST_W) state <= RUN;
    end
  end

  // Array has no reset of its own; the sweep is the only clearing path.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        mem[clr_idx] <= '0;
      end else if (accept && bus.req_write && in_range) begin
        mem[idx] <= merged;
      end
    end
  end

  dm_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_fire),
    .in_err    (rd_err),
    .in_data   (rd_data),
    .out_valid (pipe_valid),
    .out_err   (pipe_err),
    .out_data  (pipe_data)
  );

  // Responses are masked during reset so in-flight reads never surface.
  assign bus.rsp_valid = pipe_valid && !rst;
  assign bus.rsp_err   = pipe_err && !rst;
  assign bus.rsp_rdata = rst ? '0 : pipe_data;

  logic unused_bytes;
  assign unused_bytes = (BYTES == 0);

endmodule

// File: tb/tb_dm_bwe_mem.sv
// Scoreboard bench: three configurations (RD_LAT=1 clear, RD_LAT=2 clear, retain).
module tb_dm_bwe_mem;

  localparam int unsigned AW  = 5;
  localparam int unsigned DW  = 32;
  localparam int unsigned DEP = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst [3];
  logic          rv  [3];
  logic          rw  [3];
  logic [AW-1:0] ra  [3];
  logic [DW-1:0] rd  [3];
  logic [3:0]    rs  [3];

  dm_bwe_mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  dm_bwe_mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();
  dm_bwe_mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus_c ();

  assign bus_a.req_valid = rv[0];
  assign bus_a.req_write = rw[0];
  assign bus_a.req_addr  = ra[0];
  assign bus_a.req_wdata = rd[0];
  assign bus_a.req_wstrb = rs[0];
  assign bus_b.req_valid = rv[1];
  assign bus_b.req_write = rw[1];
  assign bus_b.req_addr  = ra[1];
  assign bus_b.req_wdata = rd[1];
  assign bus_b.req_wstrb = rs[1];
  assign bus_c.req_valid = rv[2];
  assign bus_c.req_write = rw[2];
  assign bus_c.req_addr  = ra[2];
  assign bus_c.req_wdata = rd[2];
  assign bus_c.req_wstrb = rs[2];

  dm_bwe_mem #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .RD_LAT(1), .CLEAR_ON_RST(1))
    dut_a (.clk(clk), .rst(rst[0]), .bus(bus_a));
  dm_bwe_mem #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .RD_LAT(2), .CLEAR_ON_RST(1))
    dut_b (.clk(clk), .rst(rst[1]), .bus(bus_b));
  dm_bwe_mem #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .RD_LAT(1), .CLEAR_ON_RST(0))
    dut_c (.clk(clk), .rst(rst[2]), .bus(bus_c));

  typedef struct {
    logic [31:0] data;
    logic        err;
    int unsigned cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  int unsigned cyc   = 0;
  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned seen [3] = '{0, 0, 0};
  int unsigned lat  [3] = '{1, 2, 1};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_rsp(input int k, input exp_t e, input logic [31:0] d, input logic err);
    chk($sformatf("rsp_data dut%0d", k), d, e.data);
    chk($sformatf("rsp_err dut%0d", k), 32'(err), 32'(e.err));
    chk($sformatf("rsp_cycle dut%0d", k), cyc, e.cyc);
  endtask

  task automatic unexpected(input int k);
    total++;
    bad++;
    $display("FAIL rsp_unexpected dut%0d: got rsp_valid=1 want 0 (cycle %0d)", k, cyc);
  endtask

  always @(negedge clk) if (bus_a.rsp_valid === 1'b1) begin
    seen[0]++;
    if (qa.size() == 0) unexpected(0);
    else chk_rsp(0, qa.pop_front(), bus_a.rsp_rdata, bus_a.rsp_err);
  end

  always @(negedge clk) if (bus_b.rsp_valid === 1'b1) begin
    seen[1]++;
    if (qb.size() == 0) unexpected(1);
    else chk_rsp(1, qb.pop_front(), bus_b.rsp_rdata, bus_b.rsp_err);
  end

  always @(negedge clk) if (bus_c.rsp_valid === 1'b1) begin
    seen[2]++;
    if (qc.size() == 0) unexpected(2);
    else chk_rsp(2, qc.pop_front(), bus_c.rsp_rdata, bus_c.rsp_err);
  end

  function automatic logic ready_of(input int k);
    case (k)
      0:       return bus_a.req_ready;
      1:       return bus_b.req_ready;
      default: return bus_c.req_ready;
    endcase
  endfunction

  function automatic logic busy_of(input int k);
    case (k)
      0:       return bus_a.init_busy;
      1:       return bus_b.init_busy;
      default: return bus_c.init_busy;
    endcase
  endfunction

  task automatic drive(input int k, input logic w, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    @(posedge clk);
    #1;
    rv[k] = 1'b1;
    rw[k] = w;
    ra[k] = a;
    rd[k] = d;
    rs[k] = s;
    chk($sformatf("req_ready dut%0d", k), 32'(ready_of(k)), 32'd1);
  endtask

  task automatic wr(input int k, input logic [AW-1:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    drive(k, 1'b1, a, d, s);
  endtask

  task automatic rdq(input int k, input logic [AW-1:0] a, input logic [31:0] exp_d,
                     input logic exp_e);
    exp_t e;
    drive(k, 1'b0, a, '0, '0);
    e.data = exp_d;
    e.err  = exp_e;
    e.cyc  = cyc + lat[k];
    case (k)
      0:       qa.push_back(e);
      1:       qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  task automatic idle(input int k);
    @(posedge clk);
    #1;
    rv[k] = 1'b0;
  endtask

  task automatic wait_init(input int k);
    int unsigned n = 0;
    @(negedge clk);
    while (busy_of(k) === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("init_done dut%0d", k), 32'(busy_of(k)), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish by 200000");
    $fatal(1);
  end

  initial begin
    int unsigned busy_n;
    int unsigned rdy_bad;
    int unsigned snap;
    bit          done;

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1;
      rv[k]  = 1'b0;
      rw[k]  = 1'b0;
      ra[k]  = '0;
      rd[k]  = '0;
      rs[k]  = '0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ready a", 32'(bus_a.req_ready), 32'd0);
    chk("rst valid a", 32'(bus_a.rsp_valid), 32'd0);
    chk("rst rdata a", bus_a.rsp_rdata, 32'd0);
    chk("rst err a",   32'(bus_a.rsp_err), 32'd0);
    chk("rst busy a",  32'(bus_a.init_busy), 32'd1);
    chk("rst busy c",  32'(bus_c.init_busy), 32'd0);
    chk("rst ready c", 32'(bus_c.req_ready), 32'd0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    @(negedge clk);
    chk("retain busy c", 32'(bus_c.init_busy), 32'd0);
    chk("retain ready c", 32'(bus_c.req_ready), 32'd1);

    // Clear sweep on dut a after preloading all ones
    wait_init(0);
    for (int a = 0; a < 16; a++) wr(0, AW'(a), 32'hFFFF_FFFF, 4'hF);
    rdq(0, 5'd5, 32'hFFFF_FFFF, 1'b0);
    idle(0);
    @(posedge clk);
    #1;
    rst[0] = 1'b1;
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    busy_n  = 0;
    rdy_bad = 0;
    done    = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus_a.init_busy) begin
        busy_n++;
        if (bus_a.req_ready) rdy_bad++;
      end else begin
        done = 1'b1;
        chk("ready after sweep", 32'(bus_a.req_ready), 32'd1);
      end
    end
    chk("sweep length", busy_n, 32'd16);
    chk("ready during sweep", rdy_bad, 32'd0);
    for (int a = 0; a < 16; a++) rdq(0, AW'(a), 32'h0, 1'b0);
    idle(0);

    // Byte strobes, including an all-zero strobe
    wr(0, 5'd3, 32'h1122_3344, 4'hF);
    wr(0, 5'd3, 32'hAABB_CCDD, 4'b0101);
    wr(0, 5'd3, 32'hFFFF_FFFF, 4'b0000);
    rdq(0, 5'd3, 32'h11BB_33DD, 1'b0);
    idle(0);

    // Out of range: write dropped without aliasing, read flags error, err holds
    wr(0, 5'd20, 32'h5, 4'hF);
    rdq(0, 5'd4, 32'h0, 1'b0);
    rdq(0, 5'd15, 32'h0, 1'b0);
    rdq(0, 5'd20, 32'h0, 1'b1);
    idle(0);
    repeat (3) @(negedge clk);
    chk("err hold valid", 32'(bus_a.rsp_valid), 32'd0);
    chk("err hold", 32'(bus_a.rsp_err), 32'd1);

    // Read immediately after write, then data hold
    wr(0, 5'd7, 32'hCAFE_F00D, 4'hF);
    rdq(0, 5'd7, 32'hCAFE_F00D, 1'b0);
    idle(0);
    repeat (3) @(negedge clk);
    chk("data hold valid", 32'(bus_a.rsp_valid), 32'd0);
    chk("data hold", bus_a.rsp_rdata, 32'hCAFE_F00D);

    // RD_LAT=2 pipelining on dut b
    wait_init(1);
    wr(1, 5'd1, 32'h0000_0101, 4'hF);
    wr(1, 5'd2, 32'h0000_0202, 4'hF);
    wr(1, 5'd3, 32'h0000_0303, 4'hF);
    rdq(1, 5'd1, 32'h0000_0101, 1'b0);
    rdq(1, 5'd2, 32'h0000_0202, 1'b0);
    rdq(1, 5'd3, 32'h0000_0303, 1'b0);
    idle(1);
    repeat (4) @(posedge clk);

    // Reset with two reads in flight on dut b
    drive(1, 1'b0, 5'd1, '0, '0);
    drive(1, 1'b0, 5'd2, '0, '0);
    @(posedge clk);
    #1;
    rst[1] = 1'b1;
    rv[1]  = 1'b0;
    snap   = seen[1];
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    repeat (6) @(negedge clk);
    chk("flush no rsp b", seen[1], snap);
    wait_init(1);
    rdq(1, 5'd2, 32'h0, 1'b0);
    idle(1);

    // Retention through reset on dut c
    wr(2, 5'd2, 32'h0000_1234, 4'hF);
    idle(2);
    @(posedge clk);
    #1;
    rst[2] = 1'b1;
    @(negedge clk);
    chk("retain rst busy c", 32'(bus_c.init_busy), 32'd0);
    chk("retain rst ready c", 32'(bus_c.req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst[2] = 1'b0;
    @(negedge clk);
    chk("retain post busy c", 32'(bus_c.init_busy), 32'd0);
    chk("retain post ready c", 32'(bus_c.req_ready), 32'd1);
    rdq(2, 5'd2, 32'h0000_1234, 1'b0);
    idle(2);

    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("drain a", qa.size(), 32'd0);
    chk("drain b", qb.size(), 32'd0);
    chk("drain c", qc.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_bwe_mem.md
Name: dm_bwe_mem

Overview:
- Parametrised single-port data memory; next generation of the core's data memory.
- Adds byte-write strobes, valid/ready request handshake and a configurable read-pipeline latency.
- Replaces the single-cycle full-array reset with a one-word-per-cycle clear sweep after reset.
- Sits between the core's MEM stage and the data array; an out-of-range error flag feeds the exception logic.

Parameters:
- ADDR_W, 16: address width, in words.
- DATA_W, 32: data width; must be a multiple of 8.
- DEPTH, 65536: number of words implemented; must be ≤ 2**ADDR_W.
- RD_LAT, 1: read latency in cycles; legal values 1 or 2.
- CLEAR_ON_RST, 1: 1 = zero-sweep the array after reset; 0 = array contents are retained through reset.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-high reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: block can accept a request this cycle.
- req_write, input, 1: 1 = write, 0 = read.
- req_addr, input, ADDR_W: word address.
- req_wdata, input, DATA_W: write data.
- req_wstrb, input, DATA_W/8: byte enables; bit i covers bits [8i+7:8i].
- rsp_valid, output, 1: read response valid.
- rsp_rdata, output, DATA_W: read data.
- rsp_err, output, 1: the read address was ≥ DEPTH.
- init_busy, output, 1: clear sweep in progress.

Behaviour:
- Reset is synchronous on clk, active-high on rst. While rst=1:
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Read pipeline flushed.
  - Clear counter set to 0.
  - init_busy=1 if CLEAR_ON_RST=1, else 0.
- States: INIT, RUN.
  - rst with CLEAR_ON_RST=1 → INIT.
  - rst with CLEAR_ON_RST=0 → RUN.
- INIT:
  - Each cycle writes 0 to mem[clr_cnt], then clr_cnt++.
  - After writing DEPTH-1, move to RUN.
  - init_busy=1 for exactly DEPTH cycles after rst deasserts; req_ready=0 throughout.
  - rst during INIT restarts the sweep from address 0.
- RUN: req_ready=1 every cycle (no internal stalls). A request is accepted on any cycle with req_valid && req_ready.
- Accepted write:
  - Bytes with wstrb=1 are updated at the accepting clock edge; other bytes unchanged.
  - wstrb=0 is a legal no-op.
  - Writes produce no response.
  - Address ≥ DEPTH: write dropped silently.
- Accepted read:
  - rsp_valid pulses high for 1 cycle, RD_LAT cycles after the accept edge.
  - RD_LAT=1: data visible in the cycle after the accept.
  - Address ≥ DEPTH: rsp_rdata=0 and rsp_err=1; otherwise rsp_err=0.
- Back-to-back reads: one response per cycle, in order, fully pipelined. There is no response backpressure; the consumer must always accept.
- When rsp_valid=0, rsp_rdata and rsp_err hold their last values.
- Write at cycle n, read of the same address at n+1: the read returns the new data. Single port, so there is no same-cycle conflict.
- rst with reads in flight: the in-flight responses are discarded; no rsp_valid after reset.
- Width rules: the DEPTH comparison is done at ADDR_W+1 bits. clr_cnt is ADDR_W+1 bits wide so that DEPTH = 2**ADDR_W terminates.

Decomposition:
- Package dm_pkg:
  - state_t enum {INIT, RUN}.
  - Function strb_merge(old, wdata, wstrb) returning the byte-merged word.
  - Constant BYTES = DATA_W/8 (as a localparam helper).
- Sub-module dm_rd_pipe: RD_LAT-deep shift register carrying {valid, err, data}, with synchronous flush on rst.
- Top module holds the array, the FSM, the clear counter and the address-range check.

Test Plan (DEPTH=16, ADDR_W=5, DATA_W=32 unless noted):
- Clear sweep: preload array to 0xFFFFFFFF, pulse rst 1 cycle → init_busy high exactly 16 cycles, req_ready=0 during sweep, rise on cycle 17; read all 16 addresses → rsp_rdata=0.
- Byte strobes: write 0x11223344 to addr 3 with wstrb=4'hF, then 0xAABBCCDD with wstrb=4'b0101, then read addr 3 → 0x11BB33DD.
- Latency/pipelining, RD_LAT=2: reads to addr 1,2,3 on consecutive cycles → rsp_valid high on 3 consecutive cycles, starting 2 cycles after the first accept, data in order.
- Out-of-range: write 0x5 to addr 20 → no array change. Read addr 20 → rsp_rdata=0, rsp_err=1. Read addr 15 → rsp_err=0.
- Read-after-write: write 0xCAFEF00D to addr 7 at cycle n, read addr 7 at n+1 → 0xCAFEF00D. Also: rst asserted with 2 reads in flight → no rsp_valid after rst.
- CLEAR_ON_RST=0: write 0x1234 to addr 2, pulse rst → init_busy stays 0, req_ready=1 the cycle after rst, read addr 2 → 0x1234.
